// File: rtl/axi4_burst_master.sv
// axi4_burst_master: single-outstanding AXI4 INCR burst master behind a simple command/beat interface.
// Illegal commands are latched like any other and retired from AW/AR without raising a valid.
module axi4_burst_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH = 4,
    parameter int MAX_LEN = 256
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [8:0]              cmd_len,
    input  logic [ID_WIDTH-1:0]     cmd_id,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_strb,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_last,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic                    done,
    output logic [1:0]              done_resp,
    output logic [ID_WIDTH-1:0]     m_axi_awid,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]              m_axi_awlen,
    output logic [2:0]              m_axi_awsize,
    output logic [1:0]              m_axi_awburst,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wlast,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [ID_WIDTH-1:0]     m_axi_bid,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    output logic [ID_WIDTH-1:0]     m_axi_arid,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [7:0]              m_axi_arlen,
    output logic [2:0]              m_axi_arsize,
    output logic [1:0]              m_axi_arburst,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [ID_WIDTH-1:0]     m_axi_rid,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rlast,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready
);
    localparam int SIZE = $clog2(DATA_WIDTH / 8);

    typedef enum logic [2:0] {IDLE, AW, WDATA, BRESP, AR, RDATA, DONE} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [8:0]            len_q;
    logic [ID_WIDTH-1:0]   id_q;
    logic                  bad_q;
    logic [8:0]            cnt;
    logic [16:0]           span;
    logic                  bad_in;
    logic                  last;
    logic                  w_hs;
    logic                  r_hs;
    logic [1:0]            r_resp;

    // Byte offset of the burst end within its 4 KB page; above 4096 means the burst crosses a page.
    assign span   = 17'(cmd_addr[11:0]) + (17'(cmd_len) << SIZE);
    assign bad_in = cmd_len == 9'd0 || cmd_len > 9'(MAX_LEN) || span > 17'd4096;
    assign last   = cnt == len_q - 9'd1;
    assign w_hs   = state == WDATA && wr_valid && m_axi_wready;
    assign r_hs   = state == RDATA && m_axi_rvalid && rd_ready;
    assign r_resp = (m_axi_rid != id_q || m_axi_rlast != last) ? (m_axi_rresp > 2'b10 ? m_axi_rresp : 2'b10) : m_axi_rresp;

    assign m_axi_awid    = id_q;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = 8'(len_q - 9'd1);
    assign m_axi_awsize  = 3'(SIZE);
    assign m_axi_awburst = 2'b01;
    assign m_axi_arid    = id_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = 8'(len_q - 9'd1);
    assign m_axi_arsize  = 3'(SIZE);
    assign m_axi_arburst = 2'b01;

    assign m_axi_wdata  = wr_data;
    assign m_axi_wstrb  = wr_strb;
    assign m_axi_wlast  = state == WDATA && last;
    assign m_axi_wvalid = state == WDATA && wr_valid;
    assign wr_ready     = state == WDATA && m_axi_wready;

    assign rd_data      = m_axi_rdata;
    assign rd_last      = state == RDATA && last;
    assign rd_valid     = state == RDATA && m_axi_rvalid;
    assign m_axi_rready = state == RDATA && rd_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            addr_q        <= '0;
            len_q         <= '0;
            id_q          <= '0;
            bad_q         <= 1'b0;
            cnt           <= '0;
            cmd_ready     <= 1'b0;
            m_axi_awvalid <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_bready  <= 1'b0;
            done          <= 1'b0;
            done_resp     <= 2'b00;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready     <= 1'b0;
                        addr_q        <= cmd_addr;
                        len_q         <= cmd_len;
                        id_q          <= cmd_id;
                        bad_q         <= bad_in;
                        cnt           <= '0;
                        done_resp     <= bad_in ? 2'b10 : 2'b00;
                        m_axi_awvalid <= cmd_write && !bad_in;
                        m_axi_arvalid <= !cmd_write && !bad_in;
                        state         <= cmd_write ? AW : AR;
                    end
                end
                AW: begin
                    if (bad_q) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (m_axi_awready) begin
                        m_axi_awvalid <= 1'b0;
                        state         <= WDATA;
                    end
                end
                AR: begin
                    if (bad_q) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        state         <= RDATA;
                    end
                end
                WDATA: begin
                    if (w_hs) begin
                        cnt <= last ? 9'd0 : cnt + 9'd1;
                        if (last) begin
                            m_axi_bready <= 1'b1;
                            state        <= BRESP;
                        end
                    end
                end
                BRESP: begin
                    if (m_axi_bvalid) begin
                        m_axi_bready <= 1'b0;
                        done_resp    <= m_axi_bid != id_q ? 2'b10 : m_axi_bresp;
                        done         <= 1'b1;
                        state        <= DONE;
                    end
                end
                RDATA: begin
                    if (r_hs) begin
                        cnt       <= last ? 9'd0 : cnt + 9'd1;
                        done_resp <= r_resp > done_resp ? r_resp : done_resp;
                        if (last) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi4_burst_master.sv
// tb_axi4_burst_master: directed bench with a small AXI slave model driven cycle by cycle.
module tb_axi4_burst_master;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr;
    logic [8:0]  cmd_len;
    logic [3:0]  cmd_id;
    logic [63:0] wr_data;
    logic [7:0]  wr_strb;
    logic        wr_valid, wr_ready;
    logic [63:0] rd_data;
    logic        rd_last, rd_valid, rd_ready;
    logic        done;
    logic [1:0]  done_resp;
    logic [3:0]  m_axi_awid, m_axi_bid, m_axi_arid, m_axi_rid;
    logic [31:0] m_axi_awaddr, m_axi_araddr;
    logic [7:0]  m_axi_awlen, m_axi_arlen, m_axi_wstrb;
    logic [2:0]  m_axi_awsize, m_axi_arsize;
    logic [1:0]  m_axi_awburst, m_axi_arburst, m_axi_bresp, m_axi_rresp;
    logic        m_axi_awvalid, m_axi_awready, m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;
    logic [63:0] m_axi_wdata, m_axi_rdata;

    always #5 clk = ~clk;

    axi4_burst_master dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id),
        .wr_data(wr_data), .wr_strb(wr_strb), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .done(done), .done_resp(done_resp),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    int checks = 0, errors = 0, cyc = 0;
    bit stall, accepted, axi_seen, b_pend, aw_stall, rd_stall;
    int w_beat, w_len, rd_n, r_len, r_beat, r_total, err_beat, rlast_beat, bid_off;
    int wlast_n, rdlast_n, done_n, aw_n, ar_n, acc_cyc, aw_cyc, w_cyc, b_cyc, done_cyc, d0;
    logic [1:0]  resp_q, err_val;
    logic [7:0]  awlen_q, arlen_q;
    logic [31:0] awaddr_q, araddr_q;
    logic [3:0]  awid_q, arid_q;
    logic [2:0]  awsize_q;
    logic [1:0]  awburst_q;
    logic [63:0] aw_prev, rd_prev;

    function automatic logic [63:0] wpat(int i);
        return 64'hC0DE_0000_0000_0000 | (64'(i) * 64'h0000_0001_0001_0001);
    endfunction

    function automatic logic [63:0] rpat(int i);
        return 64'hDA7A_0000_0000_0000 ^ (64'(i) * 64'h0000_0000_0013_5779);
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: sample at the falling edge, then drive the next cycle's inputs 1 ns after the rising edge.
    task automatic step();
        @(negedge clk);
        if (aw_stall) check("aw_hold", {19'd0, m_axi_awvalid, m_axi_awid, m_axi_awlen, m_axi_awaddr}, aw_prev);
        aw_stall = m_axi_awvalid && !m_axi_awready;
        aw_prev  = {19'd0, m_axi_awvalid, m_axi_awid, m_axi_awlen, m_axi_awaddr};
        if (rd_stall) begin
            check("rd_hold_v", 64'(rd_valid), 64'd1);
            check("rd_hold_d", rd_data, rd_prev);
        end
        rd_stall = rd_valid && !rd_ready;
        rd_prev  = rd_data;
        if (cmd_valid && cmd_ready) begin
            accepted = 1'b1;
            acc_cyc  = cyc;
        end
        if (m_axi_awvalid || m_axi_arvalid || m_axi_wvalid || m_axi_bready || m_axi_rready) axi_seen = 1'b1;
        if (m_axi_awvalid && m_axi_awready) begin
            aw_n++;
            aw_cyc    = cyc;
            awlen_q   = m_axi_awlen;
            awaddr_q  = m_axi_awaddr;
            awid_q    = m_axi_awid;
            awsize_q  = m_axi_awsize;
            awburst_q = m_axi_awburst;
        end
        if (m_axi_arvalid && m_axi_arready) begin
            ar_n++;
            arlen_q  = m_axi_arlen;
            araddr_q = m_axi_araddr;
            arid_q   = m_axi_arid;
            r_total  = int'(m_axi_arlen) + 1;
            r_beat   = 0;
        end
        if (m_axi_wvalid && m_axi_wready) begin
            check("wdata", m_axi_wdata, wpat(w_beat));
            check("wstrb", 64'(m_axi_wstrb), 64'(8'(w_beat) ^ 8'h3C));
            check("wlast", 64'(m_axi_wlast), 64'(w_beat == w_len - 1));
            wlast_n += int'(m_axi_wlast);
            if (w_beat == w_len - 1) b_pend = 1'b1;
            w_cyc = cyc;
            w_beat++;
        end
        if (m_axi_bvalid && m_axi_bready) begin
            b_pend = 1'b0;
            b_cyc  = cyc;
        end
        if (m_axi_rvalid && m_axi_rready) r_beat++;
        if (rd_valid && rd_ready) begin
            check("rd_data", rd_data, rpat(rd_n));
            check("rd_last", 64'(rd_last), 64'(rd_n == r_len - 1));
            rdlast_n += int'(rd_last);
            rd_n++;
        end
        if (done) begin
            done_n++;
            done_cyc = cyc;
            resp_q   = done_resp;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (accepted) cmd_valid = 1'b0;
        m_axi_awready = !stall || $urandom_range(0, 3) != 0;
        m_axi_wready  = !stall || $urandom_range(0, 3) != 0;
        m_axi_arready = !stall || $urandom_range(0, 3) != 0;
        m_axi_bvalid  = b_pend;
        m_axi_bid     = awid_q + 4'(bid_off);
        m_axi_bresp   = 2'b00;
        m_axi_rvalid  = r_beat < r_total;
        m_axi_rid     = arid_q;
        m_axi_rdata   = rpat(r_beat);
        m_axi_rresp   = r_beat == err_beat ? err_val : 2'b00;
        m_axi_rlast   = r_beat == (rlast_beat >= 0 ? rlast_beat : r_total - 1);
        wr_valid      = w_beat < w_len && (!stall || $urandom_range(0, 3) != 0);
        wr_data       = wpat(w_beat);
        wr_strb       = 8'(w_beat) ^ 8'h3C;
        rd_ready      = !stall || $urandom_range(0, 3) != 0;
    endtask

    task automatic issue(input logic wr, input logic [31:0] addr, input logic [8:0] len, input logic [3:0] id);
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_len   = len;
        cmd_id    = id;
        cmd_valid = 1'b1;
        accepted  = 1'b0;
        axi_seen  = 1'b0;
        w_beat    = 0;
        w_len     = wr ? int'(len) : 0;
        rd_n      = 0;
        r_len     = wr ? 0 : int'(len);
        wlast_n   = 0;
        rdlast_n  = 0;
        aw_n      = 0;
        ar_n      = 0;
        acc_cyc   = -100;
    endtask

    task automatic wait_done();
        int n = 0;
        d0 = done_n;
        while (done_n == d0 && n < 6000) begin
            step();
            n++;
        end
        check("done_seen", 64'(done_n - d0), 64'd1);
        check("done_pulse", 64'(done), 64'd0);
    endtask

    initial begin
        {cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_id} = '0;
        {wr_data, wr_strb, wr_valid, rd_ready} = '0;
        {m_axi_awready, m_axi_wready, m_axi_arready, m_axi_bvalid, m_axi_bid, m_axi_bresp} = '0;
        {m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid} = '0;
        {awid_q, arid_q} = '0;
        stall = 1'b0; err_beat = -1; err_val = 2'b10; rlast_beat = -1; bid_off = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        check("rst_valids", 64'({m_axi_awvalid, m_axi_arvalid, m_axi_wvalid, m_axi_bready, m_axi_rready, wr_ready, rd_valid}), 64'd0);
        check("rst_done", 64'({done, done_resp}), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("rdy_before_clk", 64'(cmd_ready), 64'd0);
        @(posedge clk);
        #1;
        check("rdy_after_clk", 64'(cmd_ready), 64'd1);

        // minimum-latency single-beat write
        issue(1'b1, 32'h40, 9'd1, 4'd5);
        wait_done();
        check("lat_aw", 64'(aw_cyc - acc_cyc), 64'd1);
        check("lat_w", 64'(w_cyc - acc_cyc), 64'd2);
        check("lat_b", 64'(b_cyc - acc_cyc), 64'd3);
        check("lat_done", 64'(done_cyc - acc_cyc), 64'd4);
        check("lat_rdy", 64'(cmd_ready), 64'd1);

        issue(1'b1, 32'h100, 9'd4, 4'd3);
        wait_done();
        check("w4_awlen", 64'(awlen_q), 64'd3);
        check("w4_awaddr", 64'(awaddr_q), 64'h100);
        check("w4_awid", 64'(awid_q), 64'd3);
        check("w4_awsize", 64'(awsize_q), 64'd3);
        check("w4_awburst", 64'(awburst_q), 64'd1);
        check("w4_beats", 64'(w_beat), 64'd4);
        check("w4_wlast_n", 64'(wlast_n), 64'd1);
        check("w4_resp", 64'(resp_q), 64'd0);

        err_beat = 4;
        issue(1'b0, 32'h200, 9'd8, 4'd6);
        wait_done();
        err_beat = -1;
        check("r8_arlen", 64'(arlen_q), 64'd7);
        check("r8_araddr", 64'(araddr_q), 64'h200);
        check("r8_arid", 64'(arid_q), 64'd6);
        check("r8_beats", 64'(rd_n), 64'd8);
        check("r8_rdlast_n", 64'(rdlast_n), 64'd1);
        check("r8_aw_n", 64'(aw_n), 64'd0);
        check("r8_resp", 64'(resp_q), 64'd2);

        err_beat = 0; err_val = 2'b01;
        issue(1'b0, 32'h280, 9'd2, 4'd1);
        wait_done();
        err_beat = -1; err_val = 2'b10;
        check("r2_exokay_resp", 64'(resp_q), 64'd1);

        issue(1'b1, 32'h0, 9'd0, 4'd2);
        wait_done();
        check("len0_axi", 64'(axi_seen), 64'd0);
        check("len0_resp", 64'(resp_q), 64'd2);
        check("len0_lat", 64'(done_cyc - acc_cyc), 64'd2);

        issue(1'b0, 32'hFF8, 9'd2, 4'd2);
        wait_done();
        check("x4k_axi", 64'(axi_seen), 64'd0);
        check("x4k_resp", 64'(resp_q), 64'd2);
        check("x4k_lat", 64'(done_cyc - acc_cyc), 64'd2);

        issue(1'b1, 32'h0, 9'd257, 4'd2);
        wait_done();
        check("len257_axi", 64'(axi_seen), 64'd0);
        check("len257_resp", 64'(resp_q), 64'd2);

        // ends exactly on the page boundary, so it is legal
        issue(1'b0, 32'hFF0, 9'd2, 4'd2);
        wait_done();
        check("edge4k_ar_n", 64'(ar_n), 64'd1);
        check("edge4k_resp", 64'(resp_q), 64'd0);

        stall = 1'b1;
        issue(1'b1, 32'h800, 9'd256, 4'd9);
        wait_done();
        check("w256_awlen", 64'(awlen_q), 64'd255);
        check("w256_beats", 64'(w_beat), 64'd256);
        check("w256_wlast_n", 64'(wlast_n), 64'd1);
        check("w256_resp", 64'(resp_q), 64'd0);
        issue(1'b0, 32'h2000, 9'd256, 4'd10);
        wait_done();
        check("r256_beats", 64'(rd_n), 64'd256);
        check("r256_rdlast_n", 64'(rdlast_n), 64'd1);
        check("r256_resp", 64'(resp_q), 64'd0);
        stall = 1'b0;

        bid_off = 1;
        issue(1'b1, 32'h300, 9'd2, 4'd2);
        wait_done();
        bid_off = 0;
        check("bid_resp", 64'(resp_q), 64'd2);

        rlast_beat = 1;
        issue(1'b0, 32'h400, 9'd4, 4'd4);
        wait_done();
        rlast_beat = -1;
        check("rlast_beats", 64'(rd_n), 64'd4);
        check("rlast_resp", 64'(resp_q), 64'd2);

        // reset while the third write beat is on offer
        issue(1'b1, 32'h500, 9'd8, 4'd7);
        begin
            int n = 0;
            while (w_beat < 2 && n < 100) begin
                step();
                n++;
            end
        end
        check("mid_reach", 64'(w_beat), 64'd2);
        check("mid_wvalid_pre", 64'(m_axi_wvalid), 64'd1);
        reset_n = 1'b0;
        #1;
        check("mid_wvalid", 64'(m_axi_wvalid), 64'd0);
        check("mid_others", 64'({m_axi_awvalid, m_axi_arvalid, m_axi_bready, m_axi_rready, wr_ready, rd_valid, cmd_ready, done}), 64'd0);
        w_len = 0; b_pend = 1'b0; r_total = 0; r_beat = 0; cmd_valid = 1'b0;
        d0 = done_n;
        repeat (3) step();
        reset_n = 1'b1;
        repeat (2) step();
        check("mid_no_done", 64'(done_n - d0), 64'd0);
        issue(1'b1, 32'h600, 9'd2, 4'd1);
        wait_done();
        check("post_aw_n", 64'(aw_n), 64'd1);
        check("post_awaddr", 64'(awaddr_q), 64'h600);
        check("post_beats", 64'(w_beat), 64'd2);
        check("post_resp", 64'(resp_q), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/axi4_burst_master.md
AXI4_BURST_MASTER -- requirements
Module: axi4_burst_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: width of cmd_addr and AXI addresses.
REQ-002 SHALL have parameter DATA_WIDTH, default 64: data width, a power of 2 from 32 to 1024.
REQ-003 SHALL have parameter ID_WIDTH, default 4: AXI ID width.
REQ-004 SHALL have parameter MAX_LEN, default 256: maximum beats per burst, 1..256.
REQ-005 SHALL have port clk, in, 1: single clock for all logic.
REQ-006 SHALL have port reset_n, in, 1: asynchronous, active-low reset.
REQ-007 SHALL have ports cmd_valid in 1 and cmd_ready out 1: command handshake.
REQ-008 SHALL have port cmd_write, in, 1: 1 selects a write burst, 0 a read burst.
REQ-009 SHALL have port cmd_addr, in, ADDR_WIDTH: start byte address, DATA_WIDTH/8-aligned.
REQ-010 SHALL have port cmd_len, in, 9: beat count.
REQ-011 SHALL have port cmd_id, in, ID_WIDTH: AXI ID for the burst.
REQ-012 SHALL have write-beat ports wr_data in DATA_WIDTH, wr_strb in DATA_WIDTH/8, wr_valid in 1, wr_ready out 1.
REQ-013 SHALL have read-beat ports rd_data out DATA_WIDTH, rd_last out 1, rd_valid out 1, rd_ready in 1.
REQ-014 SHALL have completion ports done out 1 (single-cycle pulse) and done_resp out 2 (burst status).
REQ-015 SHALL have AW outputs m_axi_awid, awaddr, awlen[7:0], awsize[2:0], awburst[1:0], awvalid, and input m_axi_awready.
REQ-016 SHALL have W outputs m_axi_wdata, wstrb, wlast, wvalid, and input m_axi_wready.
REQ-017 SHALL have B inputs m_axi_bid, bresp[1:0], bvalid, and output m_axi_bready.
REQ-018 SHALL have AR outputs m_axi_arid, araddr, arlen, arsize, arburst, arvalid, and input m_axi_arready.
REQ-019 SHALL have R inputs m_axi_rid, rdata, rresp, rlast, rvalid, and output m_axi_rready.

Function
REQ-020 SHALL use FSM states IDLE, AW, WDATA, BRESP, AR, RDATA, DONE, with exactly one burst in flight.
REQ-021 SHALL drive cmd_ready=1 only in IDLE; on cmd_valid&cmd_ready, latch cmd_* and enter AW (write) or AR (read) next cycle.
REQ-022 SHALL treat cmd_len=0, cmd_len>MAX_LEN, or a burst crossing a 4 KB boundary as illegal: no AXI traffic, go directly to DONE with done_resp=2'b10.
REQ-023 SHALL drive awlen/arlen=cmd_len-1, awsize/arsize=log2(DATA_WIDTH/8), awburst/arburst=2'b01 (INCR), and awid/arid=cmd_id.
REQ-024 SHALL hold awvalid/arvalid and all address fields stable from state entry until the ready handshake, then enter WDATA/RDATA; W does not start before the AW handshake.
REQ-025 In WDATA, SHALL pass through combinationally: m_axi_wvalid=wr_valid, wr_ready=m_axi_wready, wdata/wstrb direct; elsewhere wr_ready=0 and wvalid=0.
REQ-026 SHALL keep a 9-bit beat counter, cleared on state entry and incremented per accepted beat; wlast/rd_last=1 when counter==cmd_len-1; after the last beat, go to BRESP/DONE.
REQ-027 In BRESP, SHALL drive bready=1; on bvalid, record bresp (forced to 2'b10 if bid!=cmd_id), then go to DONE.
REQ-028 In RDATA, SHALL drive rd_valid=m_axi_rvalid, m_axi_rready=rd_ready, rd_data=rdata; elsewhere rready=0.
REQ-029 SHALL report done_resp as the numeric maximum of all rresp beats, forced to at least 2'b10 on an rid mismatch or when rlast disagrees with the expected last beat.
REQ-030 SHALL, in DONE, assert done=1 with done_resp valid for exactly one cycle, then return to IDLE.
REQ-031 SHALL achieve minimum latency with all readies high: 1-beat write accepted at cycle 0 -> AW 1, W 2, B 3, done 4, cmd_ready 5.

Reset
REQ-032 SHALL, while reset_n is low, asynchronously set state=IDLE, counters=0, done=0, done_resp=0, and all AXI valid/ready outputs and cmd_ready to 0; cmd_ready=1 from the first clock after release.
REQ-033 SHALL, on reset mid-burst, abandon the burst with no done pulse; the bench resets the slave at the same time.

Verification
REQ-034 SHALL be verified with: 4-beat write, addr 0x100, id 3, all readies high -> awlen=3, wlast on beat 4 only, done with done_resp=0.
REQ-035 SHALL be verified with: 8-beat read, slave rresp=2'b10 on beat 5 -> 8 rd_valid beats, rd_last on beat 8, done_resp=2'b10.
REQ-036 SHALL be verified with: cmd_len=0, and separately addr 0xFF8 with len 2 at DATA_WIDTH 64 -> no awvalid/arvalid, done_resp=2'b10 two cycles after accept.
REQ-037 SHALL be verified with: random awready/wready/wr_valid/rd_ready stalls over a 256-beat write then read -> data matches, valids stable while stalled.
REQ-038 SHALL be verified with: bid=cmd_id+1, and separately rlast early on beat 2 of 4 -> done_resp=2'b10.
REQ-039 SHALL be verified with: reset_n low during WDATA beat 3 -> all valids 0 immediately, no done, next command runs cleanly.
